// File: rtl/stage_sequencer_unit_if.sv
// Control bus between the stage sequencer and its surroundings: start/opcode/
// mem_ready in, datapath strobes and status out.
interface stage_sequencer_unit_if;
    logic       start;
    logic [2:0] opcode;
    logic       mem_ready;

    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       ALUSrc;
    logic       ALUOp;
    logic       MemToReg;

    logic       busy;
    logic       halted;
    logic       illegal;
    logic       mem_timeout;
    logic [2:0] state;
    logic [7:0] retired;

    // Side that issues start/opcode and answers memory requests
    modport master (
        output start, opcode, mem_ready,
        input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite, ALUSrc, ALUOp, MemToReg,
        input  busy, halted, illegal, mem_timeout, state, retired
    );

    // The sequencer itself
    modport slave (
        input  start, opcode, mem_ready,
        output PCWrite, IRWrite, RegWrite, MemRead, MemWrite, ALUSrc, ALUOp, MemToReg,
        output busy, halted, illegal, mem_timeout, state, retired
    );
endinterface

// File: rtl/stage_sequencer_unit.sv
// Multi-cycle instruction stage sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// control FSM with memory-wait timeout, sticky error flags and a retire counter.
module stage_sequencer_unit #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    stage_sequencer_unit_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALTED    = 3'd6
    } state_e;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_LW   = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_IL5  = 3'b101;
    localparam logic [2:0] OP_IL6  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Last wait count before the timeout fires (the MEM_WAIT_MAX-th stalled cycle)
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] wait_q, wait_d;
    logic [7:0] retired_q, retired_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;

    logic pcwrite_c, irwrite_c, regwrite_c, memread_c, memwrite_c, memtoreg_c;
    logic alusrc_c, aluop_c, alu_phase_c;

    // State, latched opcode, wait counter, retire counter and sticky flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ADD;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and strobe decode; start is only looked at in IDLE so it never
    // reaches an output, and mem_ready only matters in MEMORY
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_d     = '0;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        pcwrite_c  = 1'b0;
        irwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        memread_c  = 1'b0;
        memwrite_c = 1'b0;
        memtoreg_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                irwrite_c = 1'b1;
                state_d   = S_DECODE;
            end

            S_DECODE: begin
                // The instruction register was loaded at the end of FETCH, so
                // the opcode input is valid here and is captured for later stages
                op_d = bus.opcode;
                case (bus.opcode)
                    OP_HALT: begin
                        state_d = S_HALTED;
                    end
                    OP_IL5, OP_IL6: begin
                        illegal_d = 1'b1;
                        pcwrite_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                    default: begin
                        state_d = S_EXECUTE;
                    end
                endcase
            end

            S_EXECUTE: begin
                if (op_q == OP_LW || op_q == OP_SW) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end

            S_MEMORY: begin
                memread_c  = (op_q == OP_LW);
                memwrite_c = (op_q == OP_SW);
                if (bus.mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        pcwrite_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    // Abort without touching PC or registers
                    timeout_d = 1'b1;
                    state_d   = S_HALTED;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_WRITEBACK: begin
                regwrite_c = 1'b1;
                pcwrite_c  = 1'b1;
                memtoreg_c = (op_q == OP_LW);
                state_d    = S_FETCH;
            end

            S_HALTED: begin
                state_d = S_HALTED;
            end

            default: begin
                // Unused encoding 7 recovers to IDLE
                state_d = S_IDLE;
            end
        endcase

        retired_d = pcwrite_c ? retired_q + 8'd1 : retired_q;
    end

    // ALU selects follow the latched opcode from EXECUTE through WRITEBACK
    always_comb begin
        alu_phase_c = (state_q == S_EXECUTE) || (state_q == S_MEMORY) ||
                      (state_q == S_WRITEBACK);
        aluop_c     = alu_phase_c && (op_q == OP_SUB);
        alusrc_c    = alu_phase_c &&
                      ((op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW));
    end

    assign bus.PCWrite     = pcwrite_c;
    assign bus.IRWrite     = irwrite_c;
    assign bus.RegWrite    = regwrite_c;
    assign bus.MemRead     = memread_c;
    assign bus.MemWrite    = memwrite_c;
    assign bus.MemToReg    = memtoreg_c;
    assign bus.ALUOp       = aluop_c;
    assign bus.ALUSrc      = alusrc_c;
    assign bus.busy        = (state_q >= S_FETCH) && (state_q <= S_WRITEBACK);
    assign bus.halted      = (state_q == S_HALTED);
    assign bus.illegal     = illegal_q;
    assign bus.mem_timeout = timeout_q;
    assign bus.state       = state_q;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_stage_sequencer_unit.sv
// Randomized self-checking bench for stage_sequencer_unit against a per-instruction
// behavioural model (latency and strobe counts derived from the instruction rules).
module tb_stage_sequencer_unit;

    localparam int MAXW = 15;

    logic clock = 1'b0;
    logic reset;

    stage_sequencer_unit_if bus_if ();

    stage_sequencer_unit #(.MEM_WAIT_MAX(MAXW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Per-instruction summary: latency plus how many cycles each strobe was high
    typedef struct packed {
        logic [15:0] lat;
        logic [15:0] irw;
        logic [15:0] pcw;
        logic [15:0] rw;
        logic [15:0] mr;
        logic [15:0] mw;
        logic [15:0] m2r;
        logic [15:0] aluop;
        logic [15:0] alusrc;
        logic [2:0]  end_state;
    } obs_t;

    // Reference: what one instruction should look like, from the instruction rules
    function automatic obs_t model_instr(input logic [2:0] op, input int w);
        obs_t m;
        m = '0;
        m.irw = 16'd1;
        case (op)
            3'd0, 3'd1, 3'd2: begin
                m.lat = 16'd4; m.pcw = 16'd1; m.rw = 16'd1; m.end_state = 3'd1;
                if (op == 3'd1) m.aluop  = 16'd2;
                if (op == 3'd2) m.alusrc = 16'd2;
            end
            3'd3: begin
                if (w < MAXW) begin
                    m.lat = 16'(5 + w); m.pcw = 16'd1; m.rw = 16'd1; m.m2r = 16'd1;
                    m.mr = 16'(w + 1); m.alusrc = 16'(w + 3); m.end_state = 3'd1;
                end else begin
                    m.lat = 16'(3 + MAXW); m.mr = 16'(MAXW);
                    m.alusrc = 16'(1 + MAXW); m.end_state = 3'd6;
                end
            end
            3'd4: begin
                if (w < MAXW) begin
                    m.lat = 16'(4 + w); m.pcw = 16'd1;
                    m.mw = 16'(w + 1); m.alusrc = 16'(w + 2); m.end_state = 3'd1;
                end else begin
                    m.lat = 16'(3 + MAXW); m.mw = 16'(MAXW);
                    m.alusrc = 16'(1 + MAXW); m.end_state = 3'd6;
                end
            end
            3'd7: begin
                m.lat = 16'd2; m.end_state = 3'd6;
            end
            default: begin
                m.lat = 16'd2; m.pcw = 16'd1; m.end_state = 3'd1;
            end
        endcase
        return m;
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus_if.start = 1'b0;
        bus_if.mem_ready = 1'b0;
        bus_if.opcode = 3'd0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic start_cpu;
        bus_if.start = 1'b1;
        step;
        bus_if.start = 1'b0;
    endtask

    // Runs one instruction starting in FETCH; mem_ready rises after w stalled
    // MEMORY cycles; opcode is scrambled once DECODE is over and mem_ready is
    // random outside MEMORY
    task automatic exec_instr(input logic [2:0] op, input int w, output obs_t o);
        int mk;
        bit done;
        mk = 0;
        done = 1'b0;
        o = '0;
        o.lat = 16'hFFFF;
        o.end_state = 3'd7;
        for (int cyc = 1; cyc <= 600 && !done; cyc++) begin
            if (bus_if.state == 3'd6) begin
                o.lat = 16'(cyc - 1);
                o.end_state = 3'd6;
                done = 1'b1;
            end else begin
                if (bus_if.state == 3'd1 || bus_if.state == 3'd2) bus_if.opcode = op;
                else bus_if.opcode = 3'($urandom);
                if (bus_if.state == 3'd4) begin
                    mk++;
                    bus_if.mem_ready = (mk > w);
                end else begin
                    bus_if.mem_ready = 1'($urandom);
                end
                #1;
                o.irw    += 16'(bus_if.IRWrite);
                o.pcw    += 16'(bus_if.PCWrite);
                o.rw     += 16'(bus_if.RegWrite);
                o.mr     += 16'(bus_if.MemRead);
                o.mw     += 16'(bus_if.MemWrite);
                o.m2r    += 16'(bus_if.MemToReg);
                o.aluop  += 16'(bus_if.ALUOp);
                o.alusrc += 16'(bus_if.ALUSrc);
                if (bus_if.PCWrite) begin
                    o.lat = 16'(cyc);
                    step;
                    o.end_state = bus_if.state;
                    done = 1'b1;
                end else begin
                    step;
                end
            end
        end
        bus_if.mem_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus_if.start = 1'b0;
        bus_if.mem_ready = 1'b0;
        bus_if.opcode = 3'd0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (bus_if.state !== 3'd0) begin
            errors++; $display("FAIL reset_state got=%0d exp=0", bus_if.state);
        end
        checks++;
        if (bus_if.retired !== 8'd0) begin
            errors++; $display("FAIL reset_retired got=%0d exp=0", bus_if.retired);
        end
        checks++;
        if ({bus_if.illegal, bus_if.mem_timeout, bus_if.busy, bus_if.halted} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000",
                {bus_if.illegal, bus_if.mem_timeout, bus_if.busy, bus_if.halted});
        end
        checks++;
        if ({bus_if.PCWrite, bus_if.IRWrite, bus_if.RegWrite, bus_if.MemRead, bus_if.MemWrite,
             bus_if.ALUSrc, bus_if.ALUOp, bus_if.MemToReg} !== 8'b0) begin
            errors++; $display("FAIL reset_strobes got=%b exp=00000000",
                {bus_if.PCWrite, bus_if.IRWrite, bus_if.RegWrite, bus_if.MemRead,
                 bus_if.MemWrite, bus_if.ALUSrc, bus_if.ALUOp, bus_if.MemToReg});
        end
        reset = 1'b0;
        // Without start the unit stays in IDLE whatever mem_ready/opcode do
        for (int i = 0; i < 5; i++) begin
            bus_if.mem_ready = 1'($urandom);
            bus_if.opcode = 3'($urandom);
            step;
            checks++;
            if (bus_if.state !== 3'd0) begin
                errors++; $display("FAIL idle_hold cycle=%0d got=%0d exp=0", i, bus_if.state);
            end
        end
    endtask

    task automatic test_add;
        int exp_st [5] = '{1, 2, 3, 5, 1};
        do_reset;
        start_cpu;
        for (int i = 0; i < 5; i++) begin
            bus_if.opcode = (i < 2) ? 3'd0 : 3'($urandom);
            #1;
            checks++;
            if (bus_if.state !== 3'(exp_st[i])) begin
                errors++; $display("FAIL add_state cycle=%0d got=%0d exp=%0d", i, bus_if.state, exp_st[i]);
            end
            checks++;
            if ({bus_if.RegWrite, bus_if.PCWrite} !== ((i == 3) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL add_strobes cycle=%0d got=%b exp=%b", i,
                    {bus_if.RegWrite, bus_if.PCWrite}, (i == 3) ? 2'b11 : 2'b00);
            end
            step;
        end
        checks++;
        if (bus_if.retired !== 8'd1) begin
            errors++; $display("FAIL add_retired got=%0d exp=1", bus_if.retired);
        end
    endtask

    task automatic test_lw_wait;
        obs_t o, e;
        do_reset;
        start_cpu;
        exec_instr(3'd3, 3, o);
        e = model_instr(3'd3, 3);
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL lw_wait3 lat=%0d mr=%0d got=%h exp=%h", o.lat, o.mr, o, e);
        end
        checks++;
        if (bus_if.retired !== 8'd1) begin
            errors++; $display("FAIL lw_retired got=%0d exp=1", bus_if.retired);
        end
    endtask

    task automatic test_sw_timeout;
        obs_t o, e;
        do_reset;
        start_cpu;
        exec_instr(3'd4, 1000, o);
        e = model_instr(3'd4, 1000);
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL sw_timeout lat=%0d mw=%0d got=%h exp=%h", o.lat, o.mw, o, e);
        end
        checks++;
        if ({bus_if.state, bus_if.mem_timeout, bus_if.halted, bus_if.MemWrite, bus_if.PCWrite}
            !== {3'd6, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sw_timeout_status state=%0d tmo=%b halt=%b mw=%b pcw=%b exp=6,1,1,0,0",
                bus_if.state, bus_if.mem_timeout, bus_if.halted, bus_if.MemWrite, bus_if.PCWrite);
        end
        checks++;
        if (bus_if.retired !== 8'd0) begin
            errors++; $display("FAIL sw_timeout_retired got=%0d exp=0", bus_if.retired);
        end
    endtask

    task automatic test_illegal_halt;
        obs_t o, e;
        do_reset;
        start_cpu;
        exec_instr(3'd5, 0, o);
        e = model_instr(3'd5, 0);
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL illegal_101 got=%h exp=%h", o, e);
        end
        checks++;
        if ({bus_if.illegal, bus_if.retired} !== {1'b1, 8'd1}) begin
            errors++; $display("FAIL illegal_flag ill=%b ret=%0d exp ill=1 ret=1",
                bus_if.illegal, bus_if.retired);
        end
        exec_instr(3'd6, 0, o);
        e = model_instr(3'd6, 0);
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL illegal_110 got=%h exp=%h", o, e);
        end
        exec_instr(3'd7, 0, o);
        e = model_instr(3'd7, 0);
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL halt got=%h exp=%h", o, e);
        end
        bus_if.start = 1'b1;
        step;
        bus_if.start = 1'b0;
        repeat (3) step;
        checks++;
        if ({bus_if.state, bus_if.halted, bus_if.illegal, bus_if.retired}
            !== {3'd6, 1'b1, 1'b1, 8'd2}) begin
            errors++; $display("FAIL halted_start state=%0d halt=%b ill=%b ret=%0d exp=6,1,1,2",
                bus_if.state, bus_if.halted, bus_if.illegal, bus_if.retired);
        end
    endtask

    task automatic test_reset_mid_lw;
        obs_t o;
        bit reached;
        do_reset;
        start_cpu;
        exec_instr(3'd0, 0, o);
        checks++;
        if (bus_if.retired !== 8'd1) begin
            errors++; $display("FAIL pre_reset_retired got=%0d exp=1", bus_if.retired);
        end
        reached = 1'b0;
        for (int k = 0; k < 20 && !reached; k++) begin
            if (bus_if.state == 3'd4) reached = 1'b1;
            else begin
                bus_if.opcode = 3'd3;
                bus_if.mem_ready = 1'b0;
                step;
            end
        end
        checks++;
        if (!reached || bus_if.MemRead !== 1'b1) begin
            errors++; $display("FAIL lw_reach_memory state=%0d memread=%b exp state=4 memread=1",
                bus_if.state, bus_if.MemRead);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({bus_if.MemRead, bus_if.state, bus_if.retired, bus_if.busy} !== {1'b0, 3'd0, 8'd0, 1'b0}) begin
            errors++; $display("FAIL async_reset memread=%b state=%0d ret=%0d busy=%b exp 0,0,0,0",
                bus_if.MemRead, bus_if.state, bus_if.retired, bus_if.busy);
        end
        step;
        reset = 1'b0;
        repeat (2) step;
        checks++;
        if (bus_if.state !== 3'd0) begin
            errors++; $display("FAIL post_reset_idle got=%0d exp=0", bus_if.state);
        end
    endtask

    task automatic test_random;
        obs_t o, e;
        logic [2:0] op;
        int w;
        logic [7:0] ret;
        logic ill;
        do_reset;
        start_cpu;
        ret = 8'd0;
        ill = 1'b0;
        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 6));
            w = ($urandom_range(0, 9) == 0) ? MAXW - 1 : $urandom_range(0, 5);
            exec_instr(op, w, o);
            e = model_instr(op, w);
            ret = ret + e.pcw[7:0];
            if (op == 3'd5 || op == 3'd6) ill = 1'b1;
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL rand_instr n=%0d op=%0d w=%0d lat=%0d got=%h exp=%h",
                    n, op, w, o.lat, o, e);
            end
            checks++;
            if (bus_if.retired !== ret) begin
                errors++; $display("FAIL rand_retired n=%0d got=%0d exp=%0d", n, bus_if.retired, ret);
            end
            checks++;
            if (bus_if.illegal !== ill) begin
                errors++; $display("FAIL rand_illegal n=%0d got=%b exp=%b", n, bus_if.illegal, ill);
            end
        end
        // LW that never gets mem_ready must abort exactly at the limit
        exec_instr(3'd3, MAXW, o);
        e = model_instr(3'd3, MAXW);
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL lw_timeout got=%h exp=%h", o, e);
        end
        checks++;
        if ({bus_if.mem_timeout, bus_if.MemRead, bus_if.retired} !== {1'b1, 1'b0, ret}) begin
            errors++; $display("FAIL lw_timeout_status tmo=%b mr=%b ret=%0d exp 1,0,%0d",
                bus_if.mem_timeout, bus_if.MemRead, bus_if.retired, ret);
        end
    endtask

    task automatic test_wrap;
        obs_t o, e;
        do_reset;
        start_cpu;
        e = model_instr(3'd0, 0);
        for (int i = 1; i <= 256; i++) begin
            exec_instr(3'd0, 0, o);
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL wrap_add i=%0d got=%h exp=%h", i, o, e);
            end
            if (i == 255 || i == 256) begin
                checks++;
                if (bus_if.retired !== 8'(i)) begin
                    errors++; $display("FAIL wrap_retired i=%0d got=%0d exp=%0d", i, bus_if.retired, 8'(i));
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_lw_wait;
        test_sw_timeout;
        test_illegal_halt;
        test_reset_mid_lw;
        test_random;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
